// File: rtl/fma_norm_pkg.sv
// fma_norm_pkg: shared widths and stage types for the fma normalize/round pipeline
package fma_norm_pkg;
  localparam int NE_DEF = 11;
  localparam int NF_DEF = 52;
  localparam int FMALEN_DEF = 3*NF_DEF+6;
  typedef struct packed {
    logic                  s;
    logic [NE_DEF+1:0]     e;
    logic [FMALEN_DEF-1:0] m;
    logic                  sticky;
    logic                  zero;
  } norm_stage_t;
  typedef struct packed {
    logic              rs;
    logic [NE_DEF+1:0] re;
    logic [NF_DEF-1:0] rf;
    logic              inexact;
  } round_result_t;
endpackage

// File: rtl/fma_rne_round.sv
// fma_rne_round: combinational round-to-nearest-even of a left-normalized significand
module fma_rne_round
  import fma_norm_pkg::*;
(
  input  norm_stage_t   n_i,
  output round_result_t r_o
);
  logic [NF_DEF:0] m;
  logic g, t, up;
  always_comb begin
    m = n_i.m[FMALEN_DEF-1 -: NF_DEF+1];
    g = n_i.m[FMALEN_DEF-NF_DEF-2];
    t = |n_i.m[FMALEN_DEF-NF_DEF-3:0] | n_i.sticky;
    up = g & (m[0] | t);
    r_o.rs = n_i.s;
    // an all-ones significand wraps to zero and bumps the exponent instead
    r_o.rf = n_i.zero ? '0 : m[NF_DEF-1:0] + {{(NF_DEF-1){1'b0}}, up};
    r_o.re = n_i.zero ? '0 : n_i.e + {{(NE_DEF+1){1'b0}}, &m & up};
    r_o.inexact = g | t;
  end
endmodule

// File: rtl/fma_norm_round.sv
// fma_norm_round: two-stage normalize + RNE round pipeline; FMA_NORM_SKID_EN adds an input skid buffer
module fma_norm_round
  import fma_norm_pkg::*;
#(
  parameter int NE     = NE_DEF,
  parameter int NF     = NF_DEF,
  parameter int FMALEN = 3*NF+6,
  parameter int SW     = $clog2(FMALEN+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [FMALEN-1:0] Sm,
  input  logic [NE+1:0]     Se,
  input  logic              Ss,
  input  logic [SW-1:0]     SCnt,
  input  logic              ASticky,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Rs,
  output logic [NE+1:0]     Re,
  output logic [NF-1:0]     Rf,
  output logic              Inexact
);
  norm_stage_t   nrm_in, src, s1_q;
  round_result_t r_d, r_q;
  logic v1_q, v1_d, v2_q, v2_d, adv2, s1_en, in_fire, src_v, kill;
  always_comb begin
    nrm_in.s = Ss;
    nrm_in.e = Se - {{(NE+2-SW){1'b0}}, SCnt};
    nrm_in.m = Sm << SCnt;
    nrm_in.sticky = ASticky;
    nrm_in.zero = ~|Sm;
  end
  assign kill = reset | flush;
  assign adv2 = !v2_q | OutReady;
  assign s1_en = !v1_q | adv2;
  assign in_fire = InValid & InReady;
`ifdef FMA_NORM_SKID_EN
  norm_stage_t sk_q;
  logic sk_v_q, sk_v_d, rdy_q;
  // a parked entry always leaves before any new input, so order is kept
  assign InReady = rdy_q & !reset;
  assign src = sk_v_q ? sk_q : nrm_in;
  assign src_v = sk_v_q | in_fire;
  assign sk_v_d = kill ? 1'b0 : sk_v_q ? !s1_en : in_fire & !s1_en;
  always_ff @(posedge clk) begin
    rdy_q <= !reset & !sk_v_d;
    sk_v_q <= sk_v_d;
    if (reset) sk_q <= '0;
    else if (in_fire & !s1_en) sk_q <= nrm_in;
  end
`else
  assign InReady = !reset & s1_en;
  assign src = nrm_in;
  assign src_v = in_fire;
`endif
  always_comb begin
    v1_d = kill ? 1'b0 : s1_en ? src_v : v1_q;
    v2_d = kill ? 1'b0 : adv2 ? v1_q : v2_q;
  end
  always_ff @(posedge clk) begin
    v1_q <= v1_d;
    v2_q <= v2_d;
    if (reset) s1_q <= '0;
    else if (s1_en & src_v) s1_q <= src;
    if (reset) r_q <= '0;
    else if (adv2 & v1_q) r_q <= r_d;
  end
  fma_rne_round u_rnd (.n_i(s1_q), .r_o(r_d));
  assign OutValid = v2_q;
  assign Rs = r_q.rs;
  assign Re = r_q.re;
  assign Rf = r_q.rf;
  assign Inexact = r_q.inexact;
endmodule

// File: tb/tb_fma_norm_round.sv
// tb_fma_norm_round: randomized and directed checks of fma_norm_round against an arithmetic RNE model
module tb_fma_norm_round;
`ifdef FMA_NORM_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif
  logic clk = 1'b0;
  logic reset, flush, InValid, InReady, Ss, ASticky, OutValid, OutReady, Rs, Inexact;
  logic [161:0] Sm;
  logic [12:0] Se, Re;
  logic [7:0] SCnt;
  logic [51:0] Rf;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fma_norm_round dut (
    .clk(clk), .reset(reset), .flush(flush), .InValid(InValid), .InReady(InReady),
    .Sm(Sm), .Se(Se), .Ss(Ss), .SCnt(SCnt), .ASticky(ASticky),
    .OutValid(OutValid), .OutReady(OutReady), .Rs(Rs), .Re(Re), .Rf(Rf), .Inexact(Inexact)
  );
  function automatic logic [66:0] model(input logic [161:0] sm, input logic [12:0] se,
                                        input logic ss, input logic [7:0] sc, input logic st);
    logic [161:0] nm;
    logic [52:0] q;
    logic [108:0] rem, half;
    logic [53:0] r;
    logic [12:0] e;
    logic up;
    if (sm == 0) return {ss, 13'd0, 52'd0, st};
    nm = sm << sc;
    q = 53'(nm >> 109);
    rem = 109'(nm);
    half = 109'(1) << 108;
    up = (rem > half) || (rem == half && (st || q[0]));
    r = {1'b0, q} + 54'(up);
    e = se - 13'(sc);
    if (r == (54'(1) << 53)) return {ss, e + 13'd1, 52'd0, 1'b1};
    return {ss, e, r[51:0], (rem != 0) || st};
  endfunction
  task automatic rand_in();
    logic [191:0] w;
    logic [161:0] nm;
    int sc, k;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    nm = w[161:0];
    nm[161] = 1'b1;
    k = $urandom_range(0, 5);
    if (k == 0) begin nm[108] = 1'b1; nm[107:0] = '0; end
    if (k == 1) nm[161:108] = '1;
    sc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 161) : $urandom_range(0, 12);
    Sm = nm >> sc;
    if ($urandom_range(0, 15) == 0) Sm = '0;
    SCnt = 8'(sc);
    Se = 13'($urandom);
    Ss = 1'($urandom);
    ASticky = 1'($urandom);
  endtask
  task automatic test_reset();
    reset = 1; flush = 0; InValid = 0; OutReady = 1;
    Sm = '0; Se = '0; Ss = 0; SCnt = '0; ASticky = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL reset_inready got=%b exp=0", InReady); end
    total++;
    if ({OutValid, Rs, Re, Rf, Inexact} !== 68'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {OutValid, Rs, Re, Rf, Inexact});
    end
    @(posedge clk); #1 reset = 0;
    @(posedge clk); @(negedge clk);
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL post_reset_inready got=%b exp=1", InReady); end
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL post_reset_outvalid got=%b exp=0", OutValid); end
    @(posedge clk); #1;
  endtask
  task automatic test_directed();
    logic [161:0] sm[8];
    logic [7:0] sc[8];
    logic [12:0] se[8];
    logic ss[8], st[8];
    logic [66:0] ex[8];
    logic [161:0] one, ones;
    one = 162'd1;
    ones = ~(162'd0);
    sm[0] = one << 161; sc[0] = 0; se[0] = 1024; ss[0] = 0; st[0] = 0; ex[0] = {1'b0, 13'd1024, 52'd0, 1'b0};
    sm[1] = one << 150; sc[1] = 11; se[1] = 1030; ss[1] = 0; st[1] = 0; ex[1] = {1'b0, 13'd1019, 52'd0, 1'b0};
    sm[2] = (one << 161) | (one << 108); sc[2] = 0; se[2] = 1024; ss[2] = 0; st[2] = 0;
    ex[2] = {1'b0, 13'd1024, 52'd0, 1'b1};
    sm[3] = sm[2]; sc[3] = 0; se[3] = 1024; ss[3] = 0; st[3] = 1; ex[3] = {1'b0, 13'd1024, 52'd1, 1'b1};
    sm[4] = (one << 161) | (one << 109) | (one << 108); sc[4] = 0; se[4] = 1024; ss[4] = 0; st[4] = 0;
    ex[4] = {1'b0, 13'd1024, 52'd2, 1'b1};
    sm[5] = ones << 108; sc[5] = 0; se[5] = 1000; ss[5] = 1; st[5] = 0; ex[5] = {1'b1, 13'd1001, 52'd0, 1'b1};
    sm[6] = '0; sc[6] = 5; se[6] = 55; ss[6] = 1; st[6] = 1; ex[6] = {1'b1, 13'd0, 52'd0, 1'b1};
    sm[7] = (one << 161) | (one << 107); sc[7] = 0; se[7] = 13'h1ffc; ss[7] = 0; st[7] = 0;
    ex[7] = {1'b0, 13'h1ffc, 52'd0, 1'b1};
    OutReady = 1;
    for (int i = 0; i < 8; i++) begin
      Sm = sm[i]; SCnt = sc[i]; Se = se[i]; Ss = ss[i]; ASticky = st[i]; InValid = 1;
      @(negedge clk);
      total++; if (InReady !== 1'b1) begin bad++; $display("FAIL dir%0d_inready got=%b exp=1", i, InReady); end
      @(posedge clk); #1 InValid = 0;
      @(negedge clk);
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL dir%0d_early got=%b exp=0", i, OutValid); end
      @(posedge clk); @(negedge clk);
      total++;
      if ({OutValid, Rs, Re, Rf, Inexact} !== {1'b1, ex[i]}) begin
        bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, {OutValid, Rs, Re, Rf, Inexact}, {1'b1, ex[i]});
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_random(input int n, input int rdy_pct);
    logic [66:0] q[$];
    logic [66:0] held, exp;
    logic hv, fired;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; hv = 0; fired = 1; held = '0; InValid = 0;
    while (recv < n && cyc < 20*n + 50) begin
      if (!InValid || fired) begin
        if (sent < n && $urandom_range(0, 99) < 80) begin rand_in(); InValid = 1; end
        else InValid = 0;
      end
      OutReady = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (hv) begin
        total++;
        if ({OutValid, Rs, Re, Rf, Inexact} !== {1'b1, held}) begin
          bad++; $display("FAIL stall_hold got=%h exp=%h", {OutValid, Rs, Re, Rf, Inexact}, {1'b1, held});
        end
      end
      fired = InValid & InReady;
      if (OutValid & OutReady) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL spurious_output got=%h exp=none", {Rs, Re, Rf, Inexact}); end
        else begin
          exp = q.pop_front();
          if ({Rs, Re, Rf, Inexact} !== exp) begin
            bad++; $display("FAIL random_result got=%h exp=%h", {Rs, Re, Rf, Inexact}, exp);
          end
        end
        recv++;
      end
      hv = OutValid & !OutReady;
      held = {Rs, Re, Rf, Inexact};
      if (fired) begin q.push_back(model(Sm, Se, Ss, SCnt, ASticky)); sent++; end
      @(posedge clk); #1;
      cyc++;
    end
    InValid = 0;
    total++;
    if (recv != n || q.size() != 0) begin bad++; $display("FAIL random_count got=%0d exp=%0d", recv, n); end
  endtask
  task automatic test_backpressure();
    logic [66:0] q[$];
    logic [66:0] exp;
    logic fired;
    int acc, recv, cyc;
    acc = 0; recv = 0; cyc = 0; fired = 1; OutReady = 0; InValid = 0;
    for (int i = 0; i < 8; i++) begin
      if (fired) begin
        if (acc < 6) begin rand_in(); InValid = 1; end else InValid = 0;
      end
      @(negedge clk);
      fired = InValid & InReady;
      if (fired) begin q.push_back(model(Sm, Se, Ss, SCnt, ASticky)); acc++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (InReady !== 1'b0 || acc != CAP) begin
      bad++; $display("FAIL bp_capacity got=%0d ready=%b exp=%0d ready=0", acc, InReady, CAP);
    end
    total++;
    if ({OutValid, Rs, Re, Rf, Inexact} !== {1'b1, q[0]}) begin
      bad++; $display("FAIL bp_head got=%h exp=%h", {OutValid, Rs, Re, Rf, Inexact}, {1'b1, q[0]});
    end
    @(posedge clk); #1;
    OutReady = 1;
    while (recv < 6 && cyc < 100) begin
      if (fired) begin
        if (acc < 6) begin rand_in(); InValid = 1; end else InValid = 0;
      end
      @(negedge clk);
      fired = InValid & InReady;
      if (OutValid) begin
        total++;
        exp = (q.size() != 0) ? q.pop_front() : 67'd0;
        if ({Rs, Re, Rf, Inexact} !== exp) begin
          bad++; $display("FAIL bp_order%0d got=%h exp=%h", recv, {Rs, Re, Rf, Inexact}, exp);
        end
        recv++;
      end
      if (fired) begin q.push_back(model(Sm, Se, Ss, SCnt, ASticky)); acc++; end
      @(posedge clk); #1;
      cyc++;
    end
    InValid = 0;
    total++; if (recv != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", recv); end
  endtask
  task automatic test_flush(input logic use_reset);
    logic [66:0] exp;
    OutReady = 0;
    rand_in(); InValid = 1;
    @(posedge clk); #1 rand_in();
    @(posedge clk); #1 rand_in();
    if (use_reset) reset = 1; else flush = 1;
    @(posedge clk); #1;
    reset = 0; flush = 0; InValid = 0; OutReady = 1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL kill%0d_outvalid got=%b exp=0", use_reset, OutValid); end
    if (use_reset) begin
      total++;
      if ({Rs, Re, Rf, Inexact} !== 67'd0) begin
        bad++; $display("FAIL reset_data got=%h exp=0", {Rs, Re, Rf, Inexact});
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL kill%0d_stale got=%b exp=0", use_reset, OutValid); end
    end
    @(posedge clk); #1;
    rand_in(); InValid = 1;
    exp = model(Sm, Se, Ss, SCnt, ASticky);
    @(posedge clk); #1 InValid = 0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({OutValid, Rs, Re, Rf, Inexact} !== {1'b1, exp}) begin
      bad++; $display("FAIL kill%0d_recover got=%h exp=%h", use_reset, {OutValid, Rs, Re, Rf, Inexact}, {1'b1, exp});
    end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random(300, 100);
    test_random(400, 60);
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random(100, 50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
